// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial input and received-word outputs of the UART receiver
// Signals:
//   i_Rx_Serial   serial line into the receiver, idle high
//   o_Rx_DV       one-cycle pulse when a frame completes
//   o_Rx_Data     received word, held until the next o_Rx_DV
//   o_Parity_Err  parity mismatch on the last frame, held
//   o_Frame_Err   a stop-bit sample was 0 on the last frame, held
// Modports: master = receiver side, slave = line driver / word consumer side.
`timescale 1ns/1ps
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_Rx_Serial;
    logic                 o_Rx_DV;
    logic [DATA_BITS-1:0] o_Rx_Data;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    modport master (input i_Rx_Serial, output o_Rx_DV, o_Rx_Data, o_Parity_Err, o_Frame_Err);
    modport slave (output i_Rx_Serial, input o_Rx_DV, o_Rx_Data, o_Parity_Err, o_Frame_Err);
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver for 5-9 data bits, optional odd/even parity, 1 or 2 stop bits
// Ports:
//   i_Clock   system clock, rising edge
//   i_Reset   synchronous active-high reset
//   rx        uart_rx_frame_if.master: i_Rx_Serial in; o_Rx_DV, o_Rx_Data,
//             o_Parity_Err, o_Frame_Err out
// Option: define UART_RX_MAJORITY_EN to decide each sampled bit by a 3-sample
// majority of the synchronised line instead of a single sample.
`timescale 1ns/1ps
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input logic            i_Clock,
    input logic            i_Reset,
    uart_rx_frame_if.master rx
);
    localparam int H  = (CLKS_PER_BIT - 1) / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    // The counter reads one less than the number of edges spent in a state,
    // so the mid-start sample lands H edges after entering START.
    localparam logic [CW-1:0] MID_CNT  = CW'(H - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

    state_t               state_q, state_d;
    logic                 meta_q, rx_s_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 par_bit_q, par_bit_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 dv_q, dv_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                 bit_s, at_mid, at_end, par_err, stop_err;

`ifdef UART_RX_MAJORITY_EN
    logic h1_q, h2_q;
    always_ff @(posedge i_Clock) begin
        if (i_Reset) {h1_q, h2_q} <= 2'b11;
        else         {h1_q, h2_q} <= {rx_s_q, h1_q};
    end
    assign bit_s = (rx_s_q & h1_q) | (rx_s_q & h2_q) | (h1_q & h2_q);
`else
    assign bit_s = rx_s_q;
`endif

    assign at_mid   = cnt_q == MID_CNT;
    assign at_end   = cnt_q == LAST_CNT;
    assign stop_err = ferr_acc_q | ~bit_s;
    assign par_err  = (PARITY_MODE == 0) ? 1'b0 :
                      (PARITY_MODE == 1) ? ~(^shift_q ^ par_bit_q) : (^shift_q ^ par_bit_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        ferr_acc_d = ferr_acc_q;
        dv_d       = 1'b0;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: if (at_mid) begin
                cnt_d      = '0;
                idx_d      = '0;
                ferr_acc_d = 1'b0;
                state_d    = bit_s ? IDLE : DATA;
            end
            DATA: if (at_end) begin
                cnt_d   = '0;
                shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
                idx_d   = (idx_q == LAST_DATA) ? 4'd0 : idx_q + 4'd1;
                if (idx_q == LAST_DATA) state_d = (PARITY_MODE != 0) ? PARITY : STOP;
            end
            PARITY: if (at_end) begin
                cnt_d     = '0;
                par_bit_d = bit_s;
                state_d   = STOP;
            end
            STOP: if (at_end) begin
                cnt_d      = '0;
                idx_d      = idx_q + 4'd1;
                ferr_acc_d = stop_err;
                if (idx_q == LAST_STOP) begin
                    dv_d    = 1'b1;
                    data_d  = shift_q;
                    perr_d  = par_err;
                    ferr_d  = stop_err;
                    // a failed stop usually means a break; wait for the line to recover
                    state_d = stop_err ? BREAK_WAIT : IDLE;
                end
            end
            BREAK_WAIT: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            meta_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            ferr_acc_q <= 1'b0;
            dv_q       <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            meta_q     <= rx.i_Rx_Serial;
            rx_s_q     <= meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            ferr_acc_q <= ferr_acc_d;
            dv_q       <= dv_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx.o_Rx_DV      = dv_q;
    assign rx.o_Rx_Data    = data_q;
    assign rx.o_Parity_Err = perr_q;
    assign rx.o_Frame_Err  = ferr_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: frame-level model and per-cycle compare for an 8N1 and an 8E1 receiver
`timescale 1ns/1ps
module tb_uart_rx_frame;
    localparam int CPB = 87;
    localparam int H   = (CPB - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic i_Reset = 1'b1;
    logic rst_e = 1'b0;
    logic started = 1'b0;
    int   cyc = 0;
    int   pass_n = 0;
    int   total_n = 0;
    int   dvc_a = 0;
    int   dvc_b = 0;
    int   t0 = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t la, lb;

    always #50 clk = ~clk;

    uart_rx_frame_if #(.DATA_BITS(8)) ifa();
    uart_rx_frame_if #(.DATA_BITS(8)) ifb();

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
        .i_Clock(clk), .i_Reset(i_Reset), .rx(ifa));
    uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dut_b (
        .i_Clock(clk), .i_Reset(i_Reset), .rx(ifb));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", n, act, exp, cyc);
    endtask

    task automatic cmp(input string n, input logic dv, input logic [7:0] d, input logic pe,
                       input logic fe, ref exp_t q[$], ref exp_t l, ref int dvc);
        logic due;
        due = q.size() > 0 && q[0].cyc == cyc;
        chk({n, "_dv"}, 32'(dv), 32'(due));
        if (due) l = q.pop_front();
        if (dv) dvc = cyc;
        chk({n, "_data"}, 32'(d), 32'(l.d));
        chk({n, "_perr"}, 32'(pe), 32'(l.pe));
        chk({n, "_ferr"}, 32'(fe), 32'(l.fe));
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_e <= i_Reset;
    end

    always @(negedge clk) begin
        if (rst_e) begin
            qa.delete();
            qb.delete();
            la = '{0, 8'h00, 1'b0, 1'b0};
            lb = la;
            started = 1'b1;
        end
        if (started) begin
            cmp("a", ifa.o_Rx_DV, ifa.o_Rx_Data, ifa.o_Parity_Err, ifa.o_Frame_Err, qa, la, dvc_a);
            cmp("b", ifb.o_Rx_DV, ifb.o_Rx_Data, ifb.o_Parity_Err, ifb.o_Frame_Err, qb, lb, dvc_b);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // s: 0 = 8N1 unit, 1 = 8E1 unit. gb/gj: symbol and cycle of a one-cycle line flip.
    // rb/rj: symbol and cycle of a one-cycle reset pulse (frame then yields nothing).
    task automatic send(input int s, input logic [7:0] d, input logic pb, input logic sb,
                        input int gb, input int gj, input int rb, input int rj);
        logic       sym [11];
        logic [7:0] got;
        logic       v;
        int         len;
        exp_t       e;
        len    = s ? 11 : 10;
        sym[0] = 1'b0;
        for (int i = 0; i < 8; i++) sym[i+1] = d[i];
        sym[9]  = s ? pb : sb;
        sym[10] = sb;
        got = d;
        // a flip on the sample cycle of a data bit is seen only without majority voting
        if (gb >= 1 && gb <= 8 && gj == H && !MAJ) got[gb-1] = ~got[gb-1];
        t0    = cyc + 1;
        e.cyc = t0 + 2 + H + (len - 1) * CPB;
        e.d   = got;
        e.pe  = s ? ^{got, pb} : 1'b0;
        e.fe  = ~sb;
        if (rb < 0) begin
            if (s != 0) qb.push_back(e);
            else        qa.push_back(e);
        end
        for (int b = 0; b < len; b++) begin
            for (int j = 0; j < CPB; j++) begin
                v = sym[b] ^ (b == gb && j == gj);
                if (s != 0) ifb.i_Rx_Serial = v;
                else        ifa.i_Rx_Serial = v;
                i_Reset = (b == rb && j == rj);
                tick(1);
            end
        end
        i_Reset = 1'b0;
    endtask

    initial begin
        ifa.i_Rx_Serial = 1'b1;
        ifb.i_Rx_Serial = 1'b1;
        tick(3);
        i_Reset = 1'b0;
        tick(5);
        chk("reset_dv", 32'(ifa.o_Rx_DV), 0);
        chk("reset_data", 32'(ifa.o_Rx_Data), 0);
        chk("reset_flags", 32'({ifa.o_Parity_Err, ifa.o_Frame_Err}), 0);

        send(0, 8'h3F, 1'b0, 1'b1, -1, 0, -1, 0);
        chk("3f_latency", 32'(dvc_a - t0), 828);
        chk("3f_data", 32'(ifa.o_Rx_Data), 32'h3F);
        chk("3f_flags", 32'({ifa.o_Parity_Err, ifa.o_Frame_Err}), 0);
        send(0, 8'h55, 1'b0, 1'b1, -1, 0, -1, 0);
        send(0, 8'hAA, 1'b0, 1'b1, -1, 0, -1, 0);
        chk("b2b_data", 32'(ifa.o_Rx_Data), 32'hAA);
        tick(CPB);

        send(1, 8'hAB, 1'b1, 1'b1, -1, 0, -1, 0);
        chk("even_ok_latency", 32'(dvc_b - t0), 915);
        chk("even_ok_data", 32'(ifb.o_Rx_Data), 32'hAB);
        chk("even_ok_perr", 32'(ifb.o_Parity_Err), 0);
        tick(CPB);
        send(1, 8'hAB, 1'b0, 1'b1, -1, 0, -1, 0);
        chk("even_bad_data", 32'(ifb.o_Rx_Data), 32'hAB);
        chk("even_bad_perr", 32'(ifb.o_Parity_Err), 1);
        tick(CPB);

        send(0, 8'h81, 1'b0, 1'b0, -1, 0, -1, 0);
        chk("break_ferr", 32'(ifa.o_Frame_Err), 1);
        chk("break_data", 32'(ifa.o_Rx_Data), 32'h81);
        tick(3 * CPB);
        ifa.i_Rx_Serial = 1'b1;
        tick(CPB);
        send(0, 8'h55, 1'b0, 1'b1, -1, 0, -1, 0);
        chk("after_break_data", 32'(ifa.o_Rx_Data), 32'h55);
        chk("after_break_ferr", 32'(ifa.o_Frame_Err), 0);
        tick(CPB);

        ifa.i_Rx_Serial = 1'b0;
        tick(20);
        ifa.i_Rx_Serial = 1'b1;
        tick(2 * CPB);
        send(0, 8'hA5, 1'b0, 1'b1, -1, 0, -1, 0);
        chk("post_glitch_data", 32'(ifa.o_Rx_Data), 32'hA5);
        tick(CPB);

        // reset late in data bit 3 so the remaining high bits cannot look like a start
        send(0, 8'hF0, 1'b0, 1'b1, -1, 0, 4, CPB - 10);
        chk("rst_mid_data", 32'(ifa.o_Rx_Data), 0);
        chk("rst_mid_flags", 32'({ifa.o_Parity_Err, ifa.o_Frame_Err}), 0);
        tick(CPB);
        send(0, 8'h0F, 1'b0, 1'b1, -1, 0, -1, 0);
        chk("after_rst_data", 32'(ifa.o_Rx_Data), 32'h0F);
        tick(CPB);

        send(0, 8'h00, 1'b0, 1'b1, 1, H, -1, 0);
        chk("bit0_glitch_data", 32'(ifa.o_Rx_Data), MAJ ? 32'h00 : 32'h01);
        tick(2 * CPB);

        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
